// File: rtl/act_lut_ctrl.sv
// act_lut_ctrl: lookup sequencer and reload arbiter for the 32-lane activation LUT.
// Defining ACT_LUT_CTRL_STAT_EN adds saturating lookup/stall/reload counters.
//
// state | meaning
// RUN   | lookups accepted
// DRAIN | reload pending, waiting for in-flight reads to land in the FIFO
// LOAD  | accepting cfg words, one LUT write per word
module act_lut_ctrl #(
    parameter int LUT_WIDTH  = 24,
    parameter int LUT_DEPTH  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int LANES      = 32,
    parameter int RD_LAT     = 1,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [ADDR_WIDTH*LANES-1:0]   i_req_addr,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [LUT_WIDTH*LANES-1:0]    o_rsp_dat,
    input  logic                          i_load_start,
    input  logic [ADDR_WIDTH-1:0]         i_load_base,
    input  logic [ADDR_WIDTH-1:0]         i_load_len,
    input  logic                          i_cfg_valid,
    output logic                          o_cfg_ready,
    input  logic [LUT_WIDTH-1:0]          i_cfg_wdata,
    output logic                          o_load_busy,
    output logic                          o_load_done,
    output logic [ADDR_WIDTH*LANES-1:0]   o_lut_raddr,
    output logic                          o_lut_rd_en,
    input  logic [LUT_WIDTH*LANES-1:0]    i_lut_dat,
    output logic [ADDR_WIDTH-1:0]         o_lut_waddr,
    output logic [LUT_WIDTH-1:0]          o_lut_wdata,
    output logic                          o_lut_we
`ifdef ACT_LUT_CTRL_STAT_EN
   ,output logic [31:0]                   o_stat_lookups,
    output logic [31:0]                   o_stat_stalls,
    output logic [15:0]                   o_stat_loads
`endif
);
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [CW:0]   CREDITS  = (CW+1)'(OUT_DEPTH);
    localparam logic [LW-1:0] FULL_LEN = LW'(LUT_DEPTH);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_LOAD = 2'd2} state_t;

    state_t                       r_state, w_state_nxt;
    logic [CW-1:0]                r_inflight, r_fifo_cnt;
    logic [PW-1:0]                r_wr_ptr, r_rd_ptr;
    logic [RD_LAT-1:0]            r_vld_sr;
    logic                         r_rd_en;
    logic [ADDR_WIDTH*LANES-1:0]  r_raddr;
    logic [ADDR_WIDTH-1:0]        r_base, r_waddr;
    logic [LW-1:0]                r_len, r_widx;
    logic [LUT_WIDTH-1:0]         r_wdata;
    logic                         r_we, r_load_done;
    logic [LUT_WIDTH*LANES-1:0]   r_fifo_mem [OUT_DEPTH];

    logic                         w_req_fire, w_cfg_fire, w_last_word, w_push, w_pop;
    logic [CW:0]                  w_credit_used;

    assign w_req_fire    = i_req_valid & o_req_ready;
    assign w_cfg_fire    = i_cfg_valid & o_cfg_ready;
    assign w_last_word   = w_cfg_fire & ((r_widx + LW'(1)) == r_len);
    assign w_push        = r_vld_sr[RD_LAT-1];
    assign w_pop         = o_rsp_valid & i_rsp_ready;
    assign w_credit_used = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (i_load_start)      w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_inflight == '0)  w_state_nxt = S_LOAD;
            S_LOAD:  if (w_last_word)       w_state_nxt = S_RUN;
            default:                        w_state_nxt = S_RUN;
        endcase
    end

    // A pending start blocks acceptance so no new read can slip in behind it.
    always_comb begin
        o_req_ready = (r_state == S_RUN) & ~i_load_start & (w_credit_used < CREDITS);
        o_cfg_ready = (r_state == S_LOAD);
        o_load_busy = (r_state != S_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_en    <= 1'b0;
            r_raddr    <= '0;
            r_vld_sr   <= '0;
            r_inflight <= '0;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_rd_en     <= w_req_fire;
            if (w_req_fire) r_raddr <= i_req_addr;
            r_vld_sr[0] <= r_rd_en;
            for (int i = 1; i < RD_LAT; i++) r_vld_sr[i] <= r_vld_sr[i-1];
            case ({w_req_fire, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: ;
            endcase
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: ;
            endcase
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(OUT_DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(OUT_DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= i_lut_dat;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we        <= 1'b0;
            r_load_done <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_widx      <= '0;
        end else begin
            r_we        <= w_cfg_fire;
            r_load_done <= w_last_word;
            if (w_cfg_fire) begin
                r_waddr <= r_base + r_widx[ADDR_WIDTH-1:0];
                r_wdata <= i_cfg_wdata;
                r_widx  <= r_widx + LW'(1);
            end
            if ((r_state == S_RUN) && i_load_start) begin
                r_base <= i_load_base;
                r_len  <= (i_load_len == '0) ? FULL_LEN : {1'b0, i_load_len};
                r_widx <= '0;
            end
        end
    end

    assign o_rsp_valid = (r_fifo_cnt != '0);
    assign o_rsp_dat   = o_rsp_valid ? r_fifo_mem[r_rd_ptr] : '0;
    assign o_lut_raddr = r_raddr;
    assign o_lut_rd_en = r_rd_en;
    assign o_lut_waddr = r_waddr;
    assign o_lut_wdata = r_wdata;
    assign o_lut_we    = r_we;
    assign o_load_done = r_load_done;

`ifdef ACT_LUT_CTRL_STAT_EN
    logic [31:0] r_stat_lookups, r_stat_stalls;
    logic [15:0] r_stat_loads;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_lookups <= '0;
            r_stat_stalls  <= '0;
            r_stat_loads   <= '0;
        end else begin
            if (w_req_fire && (r_stat_lookups != '1))               r_stat_lookups <= r_stat_lookups + 32'd1;
            if (i_req_valid && !o_req_ready && (r_stat_stalls != '1)) r_stat_stalls <= r_stat_stalls + 32'd1;
            if (r_load_done && (r_stat_loads != '1))                r_stat_loads   <= r_stat_loads + 16'd1;
        end
    end

    assign o_stat_lookups = r_stat_lookups;
    assign o_stat_stalls  = r_stat_stalls;
    assign o_stat_loads   = r_stat_loads;
`endif
endmodule

// File: tb/tb_act_lut_ctrl.sv
// Directed bench for act_lut_ctrl with a behavioural 1-cycle LUT RAM.
// Build with ACT_LUT_CTRL_STAT_EN defined to include the statistics scenario.
module tb_act_lut_ctrl;
    localparam int AW = 4, DW = 24, LN = 32, DEPTH = 16;

    logic               i_clk = 1'b0, i_rst = 1'b1;
    logic               i_req_valid = 1'b0, i_rsp_ready = 1'b0;
    logic [AW*LN-1:0]   i_req_addr = '0;
    logic               i_load_start = 1'b0, i_cfg_valid = 1'b0;
    logic [AW-1:0]      i_load_base = '0, i_load_len = '0;
    logic [DW-1:0]      i_cfg_wdata = '0;
    logic [DW*LN-1:0]   i_lut_dat;
    logic               o_req_ready, o_rsp_valid, o_cfg_ready, o_load_busy, o_load_done;
    logic [DW*LN-1:0]   o_rsp_dat;
    logic [AW*LN-1:0]   o_lut_raddr;
    logic               o_lut_rd_en, o_lut_we;
    logic [AW-1:0]      o_lut_waddr;
    logic [DW-1:0]      o_lut_wdata;
`ifdef ACT_LUT_CTRL_STAT_EN
    logic [31:0]        o_stat_lookups, o_stat_stalls;
    logic [15:0]        o_stat_loads;
`endif

    int n_vec = 0, n_err = 0;
    logic          lut_init = 1'b1;
    logic [DW-1:0] lut_mem [DEPTH];
    logic [DW-1:0] exp_tab [DEPTH];

    act_lut_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dat(o_rsp_dat),
        .i_load_start(i_load_start), .i_load_base(i_load_base), .i_load_len(i_load_len),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready), .i_cfg_wdata(i_cfg_wdata),
        .o_load_busy(o_load_busy), .o_load_done(o_load_done),
        .o_lut_raddr(o_lut_raddr), .o_lut_rd_en(o_lut_rd_en), .i_lut_dat(i_lut_dat),
        .o_lut_waddr(o_lut_waddr), .o_lut_wdata(o_lut_wdata), .o_lut_we(o_lut_we)
`ifdef ACT_LUT_CTRL_STAT_EN
       ,.o_stat_lookups(o_stat_lookups), .o_stat_stalls(o_stat_stalls), .o_stat_loads(o_stat_loads)
`endif
    );

    always #5 i_clk = ~i_clk;

    // External LUT RAM: synchronous read, one cycle latency.
    always @(posedge i_clk) begin
        if (lut_init)
            for (int i = 0; i < DEPTH; i++) lut_mem[i] <= DW'(32'hC30000 + i * 32'h010101);
        else if (o_lut_we)
            lut_mem[o_lut_waddr] <= o_lut_wdata;
        if (o_lut_rd_en)
            for (int k = 0; k < LN; k++) i_lut_dat[DW*k +: DW] <= lut_mem[o_lut_raddr[AW*k +: AW]];
    end

    function automatic logic [AW*LN-1:0] addr_vec(input int off);
        logic [AW*LN-1:0] v;
        for (int k = 0; k < LN; k++) v[AW*k +: AW] = AW'((k + off) % DEPTH);
        return v;
    endfunction

    function automatic logic [DW*LN-1:0] exp_vec(input int off);
        logic [DW*LN-1:0] v;
        for (int k = 0; k < LN; k++) v[DW*k +: DW] = exp_tab[(k + off) % DEPTH];
        return v;
    endfunction

    task automatic next_cycle;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; lut_init = 1'b1;
        repeat (3) next_cycle;
        i_rst = 1'b0; lut_init = 1'b0;
        @(negedge i_clk);
        n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", o_req_ready); end
        n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", o_rsp_valid); end
        n_vec++; if (o_rsp_dat !== '0) begin n_err++; $display("FAIL reset_rsp_dat: got nonzero want 0"); end
        n_vec++; if ({o_lut_rd_en, o_lut_we, o_cfg_ready, o_load_busy, o_load_done} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl_outs: got %b want 00000", {o_lut_rd_en, o_lut_we, o_cfg_ready, o_load_busy, o_load_done});
        end
        n_vec++; if (o_lut_raddr !== '0) begin n_err++; $display("FAIL reset_raddr: got %h want 0", o_lut_raddr); end
    endtask

    task automatic test_lookup;
        next_cycle;
        i_req_valid = 1'b1; i_req_addr = addr_vec(0);
        @(negedge i_clk);
        n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL lookup_accept: got %b want 1", o_req_ready); end
        next_cycle;
        i_req_valid = 1'b0;
        @(negedge i_clk);
        n_vec++; if (o_lut_rd_en !== 1'b1) begin n_err++; $display("FAIL lookup_rd_en: got %b want 1", o_lut_rd_en); end
        n_vec++; if (o_lut_raddr !== addr_vec(0)) begin n_err++; $display("FAIL lookup_raddr: got %h want %h", o_lut_raddr, addr_vec(0)); end
        next_cycle;
        @(negedge i_clk);
        n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL lookup_early_valid: got %b want 0", o_rsp_valid); end
        next_cycle;
        @(negedge i_clk);
        n_vec++; if (o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL lookup_valid_n3: got %b want 1", o_rsp_valid); end
        n_vec++; if (o_rsp_dat !== exp_vec(0)) begin n_err++; $display("FAIL lookup_data: got %h want %h", o_rsp_dat, exp_vec(0)); end
        i_rsp_ready = 1'b1;
        next_cycle;
        i_rsp_ready = 1'b0;
        @(negedge i_clk);
        n_vec++; if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL lookup_pop: got %b want 0", o_rsp_valid); end
    endtask

    task automatic test_backpressure;
        int acc = 0, got = 0;
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            next_cycle;
            i_req_valid = 1'b1; i_req_addr = addr_vec(i + 1);
            @(negedge i_clk);
            if (o_req_ready) acc++;
        end
        next_cycle;
        i_req_valid = 1'b0;
        @(negedge i_clk);
        n_vec++; if (acc != 4) begin n_err++; $display("FAIL bp_accept_count: got %0d want 4", acc); end
        n_vec++; if (o_req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", o_req_ready); end
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (o_rsp_valid) begin
                n_vec++; if (o_rsp_dat !== exp_vec(got + 1)) begin n_err++; $display("FAIL bp_order_%0d: got %h want %h", got, o_rsp_dat, exp_vec(got + 1)); end
                n_vec++; if (c != got) begin n_err++; $display("FAIL bp_gap_%0d: seen at cycle %0d want %0d", got, c, got); end
                got++;
            end
            @(negedge i_clk);
        end
        i_rsp_ready = 1'b0;
        n_vec++; if (got != 4) begin n_err++; $display("FAIL bp_result_count: got %0d want 4", got); end
    endtask

    task automatic test_back_to_back;
        int got = 0;
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            next_cycle;
            i_req_valid = (c < 8); i_req_addr = addr_vec(7 + c);
            @(negedge i_clk);
            if (c < 8) begin
                n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b want 1", c, o_req_ready); end
            end
            if (o_rsp_valid) begin
                n_vec++; if (o_rsp_dat !== exp_vec(7 + got)) begin n_err++; $display("FAIL b2b_data_%0d: got %h want %h", got, o_rsp_dat, exp_vec(7 + got)); end
                n_vec++; if (c != got + 3) begin n_err++; $display("FAIL b2b_timing_%0d: cycle %0d want %0d", got, c, got + 3); end
                got++;
            end
        end
        i_req_valid = 1'b0;
        n_vec++; if (got != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", got); end
    endtask

    task automatic test_reload_drain;
        logic [DW-1:0] wd [4];
        int            ea [4];
        wd = '{24'hA10001, 24'hA20002, 24'hA30003, 24'hA40004};
        ea = '{14, 15, 0, 1};
        i_rsp_ready = 1'b1;
        next_cycle; i_req_valid = 1'b1; i_req_addr = addr_vec(0);
        next_cycle; i_req_addr = addr_vec(1);
        next_cycle; i_req_valid = 1'b0; i_load_start = 1'b1; i_load_base = 4'd14; i_load_len = 4'd4;
        next_cycle; i_load_start = 1'b0;
        @(negedge i_clk);
        n_vec++; if (o_load_busy !== 1'b1) begin n_err++; $display("FAIL drain_busy: got %b want 1", o_load_busy); end
        n_vec++; if (o_cfg_ready !== 1'b0) begin n_err++; $display("FAIL drain_cfg_ready_a: got %b want 0", o_cfg_ready); end
        next_cycle;
        @(negedge i_clk);
        n_vec++; if (o_cfg_ready !== 1'b0) begin n_err++; $display("FAIL drain_cfg_ready_b: got %b want 0", o_cfg_ready); end
        for (int c = 0; c < 5; c++) begin
            next_cycle;
            i_cfg_valid = (c < 4); i_cfg_wdata = wd[c % 4];
            @(negedge i_clk);
            if (c < 4) begin
                n_vec++; if (o_cfg_ready !== 1'b1) begin n_err++; $display("FAIL reload_cfg_ready_%0d: got %b want 1", c, o_cfg_ready); end
            end
            if (c > 0) begin
                n_vec++; if (o_lut_we !== 1'b1 || o_lut_waddr !== AW'(ea[c-1]) || o_lut_wdata !== wd[c-1]) begin
                    n_err++; $display("FAIL reload_write_%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", c-1, o_lut_we, o_lut_waddr, o_lut_wdata, ea[c-1], wd[c-1]);
                end
                n_vec++; if (o_load_done !== (c == 4)) begin n_err++; $display("FAIL reload_done_%0d: got %b want %b", c-1, o_load_done, (c == 4)); end
            end
        end
        i_cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_tab[ea[i]] = wd[i];
        next_cycle; i_req_valid = 1'b1; i_req_addr = addr_vec(0);
        @(negedge i_clk);
        n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL post_load_accept: got %b want 1", o_req_ready); end
        next_cycle; i_req_valid = 1'b0;
        next_cycle;
        next_cycle;
        @(negedge i_clk);
        n_vec++; if (o_rsp_valid !== 1'b1 || o_rsp_dat !== exp_vec(0)) begin
            n_err++; $display("FAIL post_load_data: got v=%b %h want v=1 %h", o_rsp_valid, o_rsp_dat, exp_vec(0));
        end
    endtask

    task automatic test_start_collision_len0;
        int  sent = 0, wr = 0;
        bit  done_seen = 1'b0;
        i_rsp_ready = 1'b1;
        next_cycle;
        i_load_start = 1'b1; i_load_base = 4'd3; i_load_len = 4'd0;
        i_req_valid = 1'b1; i_req_addr = addr_vec(2);
        @(negedge i_clk);
        n_vec++; if (o_req_ready !== 1'b0) begin n_err++; $display("FAIL collide_ready: got %b want 0", o_req_ready); end
        next_cycle;
        i_load_start = 1'b0; i_req_valid = 1'b0;
        @(negedge i_clk);
        n_vec++; if (o_load_busy !== 1'b1) begin n_err++; $display("FAIL collide_busy: got %b want 1", o_load_busy); end
        for (int c = 0; c < 40 && !done_seen; c++) begin
            next_cycle;
            i_cfg_valid = (sent < 16); i_cfg_wdata = DW'(32'hE00000 + sent);
            @(negedge i_clk);
            if (o_lut_we) begin
                n_vec++; if (o_lut_waddr !== AW'((3 + wr) % 16) || o_lut_wdata !== DW'(32'hE00000 + wr)) begin
                    n_err++; $display("FAIL len0_write_%0d: got addr=%0d data=%h want addr=%0d data=%h", wr, o_lut_waddr, o_lut_wdata, (3 + wr) % 16, 32'hE00000 + wr);
                end
                wr++;
            end
            if (o_load_done) begin
                done_seen = 1'b1;
                n_vec++; if (wr != 16) begin n_err++; $display("FAIL len0_write_count: got %0d want 16", wr); end
            end
            if (i_cfg_valid && o_cfg_ready) sent++;
        end
        i_cfg_valid = 1'b0;
        n_vec++; if (!done_seen) begin n_err++; $display("FAIL len0_done_timeout: got no done want done"); end
        for (int j = 0; j < 16; j++) exp_tab[(3 + j) % 16] = DW'(32'hE00000 + j);
        next_cycle; i_req_valid = 1'b1; i_req_addr = addr_vec(5);
        next_cycle; i_req_valid = 1'b0;
        next_cycle;
        next_cycle;
        @(negedge i_clk);
        n_vec++; if (o_rsp_valid !== 1'b1 || o_rsp_dat !== exp_vec(5)) begin
            n_err++; $display("FAIL len0_lookup: got v=%b %h want v=1 %h", o_rsp_valid, o_rsp_dat, exp_vec(5));
        end
    endtask

    task automatic test_reset_midload;
        int w = 0;
        int done_cnt = 0;
        i_rsp_ready = 1'b0;
        next_cycle; i_req_valid = 1'b1; i_req_addr = addr_vec(9);
        next_cycle; i_req_valid = 1'b0; i_load_start = 1'b1; i_load_base = 4'd0; i_load_len = 4'd4;
        next_cycle; i_load_start = 1'b0;
        @(negedge i_clk);
        while (!o_cfg_ready && w < 10) begin next_cycle; @(negedge i_clk); w++; end
        n_vec++; if (o_cfg_ready !== 1'b1) begin n_err++; $display("FAIL midload_cfg_wait: got %b want 1", o_cfg_ready); end
        i_cfg_valid = 1'b1; i_cfg_wdata = 24'hF10000;
        next_cycle; i_cfg_wdata = 24'hF20000;
        @(negedge i_clk); if (o_load_done) done_cnt++;
        next_cycle; i_cfg_valid = 1'b0; i_rst = 1'b1;
        @(negedge i_clk); if (o_load_done) done_cnt++;
        next_cycle; i_rst = 1'b0; i_rsp_ready = 1'b1; i_req_valid = 1'b1; i_req_addr = addr_vec(0);
        @(negedge i_clk);
        n_vec++; if ({o_load_busy, o_rsp_valid, o_cfg_ready, o_lut_we} !== 4'b0) begin
            n_err++; $display("FAIL midload_reset_state: got busy/rspv/cfgr/we=%b want 0000", {o_load_busy, o_rsp_valid, o_cfg_ready, o_lut_we});
        end
        n_vec++; if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL midload_accept: got %b want 1", o_req_ready); end
        exp_tab[0] = 24'hF10000; exp_tab[1] = 24'hF20000;
        for (int c = 0; c < 3; c++) begin
            if (o_load_done) done_cnt++;
            next_cycle; i_req_valid = 1'b0;
            @(negedge i_clk);
        end
        n_vec++; if (done_cnt != 0) begin n_err++; $display("FAIL midload_no_done: got %0d pulses want 0", done_cnt); end
        n_vec++; if (o_rsp_valid !== 1'b1 || o_rsp_dat !== exp_vec(0)) begin
            n_err++; $display("FAIL midload_lookup: got v=%b %h want v=1 %h", o_rsp_valid, o_rsp_dat, exp_vec(0));
        end
    endtask

`ifdef ACT_LUT_CTRL_STAT_EN
    task automatic test_stats;
        int w = 0;
        i_rst = 1'b1; i_rsp_ready = 1'b0;
        next_cycle; next_cycle; i_rst = 1'b0;
        for (int i = 0; i < 7; i++) begin next_cycle; i_req_valid = 1'b1; i_req_addr = addr_vec(i); end
        next_cycle; i_req_valid = 1'b0; i_rsp_ready = 1'b1;
        repeat (6) next_cycle;
        for (int i = 0; i < 6; i++) begin next_cycle; i_req_valid = 1'b1; i_req_addr = addr_vec(i); end
        next_cycle; i_req_valid = 1'b0;
        repeat (4) next_cycle;
        i_load_start = 1'b1; i_load_base = 4'd5; i_load_len = 4'd1;
        next_cycle; i_load_start = 1'b0;
        @(negedge i_clk);
        while (!o_cfg_ready && w < 10) begin next_cycle; @(negedge i_clk); w++; end
        i_cfg_valid = 1'b1; i_cfg_wdata = 24'h5A5A5A;
        next_cycle; i_cfg_valid = 1'b0;
        exp_tab[5] = 24'h5A5A5A;
        repeat (3) next_cycle;
        @(negedge i_clk);
        n_vec++; if (o_stat_lookups !== 32'd10) begin n_err++; $display("FAIL stat_lookups: got %0d want 10", o_stat_lookups); end
        n_vec++; if (o_stat_stalls !== 32'd3) begin n_err++; $display("FAIL stat_stalls: got %0d want 3", o_stat_stalls); end
        n_vec++; if (o_stat_loads !== 16'd1) begin n_err++; $display("FAIL stat_loads: got %0d want 1", o_stat_loads); end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_tab[i] = DW'(32'hC30000 + i * 32'h010101);
        test_reset;
        test_lookup;
        test_backpressure;
        test_back_to_back;
        test_reload_drain;
        test_start_collision_len0;
        test_reset_midload;
`ifdef ACT_LUT_CTRL_STAT_EN
        test_stats;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
